// File: rtl/param_universal_shift_register_if.sv
// Command/status bundle for param_universal_shift_register.
//   master: command source (drives cmd_*, par_in, serial fill bits)
//   slave : the shift register (drives cmd_ready, out, ser_out, busy, done)
interface param_universal_shift_register_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] par_in;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] out;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, par_in, ser_in_r, ser_in_l,
    input  cmd_ready, out, ser_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, par_in, ser_in_r, ser_in_l,
    output cmd_ready, out, ser_out, busy, done
  );
endinterface

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register running multi-step commands.
// A command (op, count) is accepted when cmd_valid && cmd_ready; its first
// step executes on the acceptance edge and further steps run one per clock
// in RUN. done pulses for one cycle after the final step.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - command handshake, parallel/serial data and status (slave side)
module param_universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                             clk,
  input logic                             rst,
  param_universal_shift_register_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SL   = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic             do_step;
  logic [WIDTH-1:0] step_out;
  logic             step_ser;
  logic             step_is_shift;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      out_q   <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  // Next-state: acceptance in IDLE executes the first step immediately
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    step_op = op_q;
    do_step = 1'b0;
    case (state_q)
      IDLE: begin
        step_op = bus.cmd_op;
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          if (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_CLR) begin
            do_step = 1'b1;
            done_d  = 1'b1;
          end else if (bus.cmd_count <= CNT_W'(1)) begin
            // count 0 still completes, but performs no step
            do_step = (bus.cmd_count != '0);
            done_d  = 1'b1;
          end else begin
            do_step = 1'b1;
            rem_d   = bus.cmd_count - CNT_W'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        do_step = 1'b1;
        rem_d   = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One step of the selected operation
  always_comb begin
    step_out      = out_q;
    step_ser      = ser_q;
    step_is_shift = 1'b0;
    case (step_op)
      OP_HOLD: step_out = out_q;
      OP_SRL: begin
        step_out      = {bus.ser_in_r, out_q[WIDTH-1:1]};
        step_ser      = out_q[0];
        step_is_shift = 1'b1;
      end
      OP_SL: begin
        step_out      = {out_q[WIDTH-2:0], bus.ser_in_l};
        step_ser      = out_q[WIDTH-1];
        step_is_shift = 1'b1;
      end
      OP_LOAD: step_out = bus.par_in;
      OP_ROR: begin
        step_out      = {out_q[0], out_q[WIDTH-1:1]};
        step_ser      = out_q[0];
        step_is_shift = 1'b1;
      end
      OP_ROL: begin
        step_out      = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        step_ser      = out_q[WIDTH-1];
        step_is_shift = 1'b1;
      end
      OP_ASR: begin
        step_out      = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
        step_ser      = out_q[0];
        step_is_shift = 1'b1;
      end
      OP_CLR: step_out = '0;
      default: step_out = out_q;
    endcase
    out_d = do_step ? step_out : out_q;
    ser_d = (do_step && step_is_shift) ? step_ser : ser_q;
  end

  assign bus.out       = out_q;
  assign bus.ser_out   = ser_q;
  assign bus.done      = done_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register (WIDTH=8, CNT_W=4).
module tb_param_universal_shift_register;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;

  param_universal_shift_register_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  param_universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] par;
    logic       sr;
    logic       sl;
    logic [7:0] exp_out;
    logic       exp_ser;
    int         exp_edges;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command starting just after an edge, wait (bounded) for done.
  task automatic run_vec(input vec_t v, input string tag);
    int  edges;
    int  busy_cnt;
    logic seen;
    bus.cmd_op    = v.op;
    bus.cmd_count = v.cnt;
    bus.par_in    = v.par;
    bus.ser_in_r  = v.sr;
    bus.ser_in_l  = v.sl;
    bus.cmd_valid = 1'b1;
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    edges    = 1;
    busy_cnt = 0;
    seen     = bus.done;
    while (seen !== 1'b1 && edges < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      edges++;
      seen = bus.done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_edges"}, 32'(edges), 32'(v.exp_edges));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(v.exp_edges - 1));
    check({tag, "_out"}, 32'(bus.out), 32'(v.exp_out));
    check({tag, "_ser_out"}, 32'(bus.ser_out), 32'(v.exp_ser));
    @(posedge clk); #1;
    check({tag, "_done_once"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // op, cnt, par, sr, sl, exp_out, exp_ser, exp_edges (state carries over)
    vecs[0]  = '{3'b011, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[1]  = '{3'b101, 4'd3,  8'h00, 1'b0, 1'b0, 8'h2D, 1'b1, 3};
    vecs[2]  = '{3'b011, 4'd9,  8'h96, 1'b0, 1'b0, 8'h96, 1'b1, 1};
    vecs[3]  = '{3'b110, 4'd2,  8'h00, 1'b0, 1'b0, 8'hE5, 1'b1, 2};
    vecs[4]  = '{3'b111, 4'd5,  8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1};
    vecs[5]  = '{3'b001, 4'd4,  8'h00, 1'b1, 1'b0, 8'hF0, 1'b0, 4};
    vecs[6]  = '{3'b010, 4'd3,  8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 3};
    vecs[7]  = '{3'b000, 4'd5,  8'h00, 1'b1, 1'b1, 8'h80, 1'b1, 5};
    vecs[8]  = '{3'b100, 4'd1,  8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 1};
    vecs[9]  = '{3'b011, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
    vecs[10] = '{3'b001, 4'd0,  8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1};
    vecs[11] = '{3'b101, 4'd15, 8'h00, 1'b0, 1'b0, 8'h1E, 1'b0, 15};
    vecs[12] = '{3'b010, 4'd1,  8'h00, 1'b0, 1'b1, 8'h3D, 1'b0, 1};
    vecs[13] = '{3'b110, 4'd1,  8'h00, 1'b0, 1'b0, 8'h1E, 1'b1, 1};
    vecs[14] = '{3'b100, 4'd2,  8'h00, 1'b0, 1'b0, 8'h87, 1'b1, 2};
    vecs[15] = '{3'b001, 4'd1,  8'h00, 1'b0, 1'b0, 8'h43, 1'b1, 1};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_count = '0;
    bus.par_in    = '0;
    bus.ser_in_r  = 1'b0;
    bus.ser_in_l  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(bus.out), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset between edges clears everything at once
    v = '{3'b011, 4'd0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1};
    run_vec(v, "pre_rst_load");
    #3 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(bus.out), 32'h00);
    check("async_rst_ser", 32'(bus.ser_out), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("async_rst_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ROL x3 step by step; a command pulsed while busy is ignored
    v = '{3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1};
    run_vec(v, "rol_load");
    bus.cmd_op = 3'b101; bus.cmd_count = 4'd3; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("rol_s1_out", 32'(bus.out), 32'h4B);
    check("rol_s1_busy", 32'(bus.busy), 32'd1);
    bus.cmd_op = 3'b011; bus.par_in = 8'hFF; bus.cmd_count = 4'd0; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("rol_s2_out", 32'(bus.out), 32'h96);
    check("rol_s2_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("rol_s3_out", 32'(bus.out), 32'h2D);
    check("rol_s3_done", 32'(bus.done), 32'd1);
    check("rol_s3_ser", 32'(bus.ser_out), 32'd1);
    check("rol_s3_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("rol_after_out", 32'(bus.out), 32'h2D);
    check("rol_after_done", 32'(bus.done), 32'd0);

    // Reset in the middle of SRL x4 discards the command
    v = '{3'b111, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1};
    run_vec(v, "mid_clear");
    bus.cmd_op = 3'b001; bus.cmd_count = 4'd4; bus.ser_in_r = 1'b1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("mid_s1_out", 32'(bus.out), 32'h80);
    @(posedge clk); #1;
    check("mid_s2_out", 32'(bus.out), 32'hC0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", 32'(bus.out), 32'h00);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_nodone%0d", i), 32'(bus.done), 32'd0);
      check($sformatf("mid_hold%0d", i), 32'(bus.out), 32'h00);
    end
    v = '{3'b011, 4'd0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1};
    run_vec(v, "mid_next");

    // count=0 shift, then a new command accepted in the done cycle
    v = '{3'b011, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
    run_vec(v, "b2b_load");
    bus.cmd_op = 3'b010; bus.cmd_count = 4'd0; bus.ser_in_l = 1'b1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_c0_out", 32'(bus.out), 32'h3C);
    check("b2b_c0_done", 32'(bus.done), 32'd1);
    check("b2b_c0_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_count = 4'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("b2b_sl_out", 32'(bus.out), 32'h79);
    check("b2b_sl_ser", 32'(bus.ser_out), 32'd0);
    check("b2b_sl_done", 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    check("b2b_end_done", 32'(bus.done), 32'd0);
    check("b2b_end_out", 32'(bus.out), 32'h79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
